operand_dispatch: RTL and testbench



---
 rtl/adder_pkg.sv | 17 +
 rtl/operand_dispatch.sv | 120 ++++++++++++
 tb/tb_operand_dispatch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder/comparator datapath: dispatch FSM states, op codes
// and field widths used by both the dispatcher and the result-select mux.
package adder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StHold
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_CMP = 1'b1;

   localparam int unsigned CMP_W     = 6;
   localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/operand_dispatch.sv
// Issues one operation into the combinational adder/comparator datapath, waits a fixed
// latency, then captures the mux result and holds it on a valid/ready output channel.
module operand_dispatch
   import adder_pkg::*;
#(
   parameter int unsigned N   = 16,
   parameter int unsigned LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_cin,
   input  logic             in_op,
   output logic [N-1:0]     add_a,
   output logic [N-1:0]     add_b,
   output logic             add_cin,
   output logic [CMP_W-1:0] cmp_a,
   output logic [CMP_W-1:0] cmp_b,
   output logic             sel,
   input  logic [N-1:0]     res_in,
   input  logic             co_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_res,
   output logic             out_co
);

   localparam logic [LAT_CNT_W-1:0] LatLoad = LAT_CNT_W'(LAT - 1);

   state_e               state_q, state_d;
   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]         add_a_q, add_a_d;
   logic [N-1:0]         add_b_q, add_b_d;
   logic                 add_cin_q, add_cin_d;
   logic                 sel_q, sel_d;
   logic [N-1:0]         out_res_q, out_res_d;
   logic                 out_co_q, out_co_d;
   logic                 out_valid_q, out_valid_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_cin_d   = add_cin_q;
      sel_d       = sel_q;
      out_res_d   = out_res_q;
      out_co_d    = out_co_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               add_a_d   = in_a;
               add_b_d   = in_b;
               add_cin_d = in_cin;
               sel_d     = in_op;
               cnt_d     = LatLoad;
               state_d   = StExec;
            end
         end
         StExec: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - LAT_CNT_W'(1);
            end else begin
               out_res_d   = res_in;
               out_co_d    = co_in;
               out_valid_d = 1'b1;
               state_d     = StHold;
            end
         end
         StHold: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         sel_q       <= 1'b0;
         out_res_q   <= '0;
         out_co_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
         sel_q       <= sel_d;
         out_res_q   <= out_res_d;
         out_co_q    <= out_co_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   // Comparator always sees the low operand bits; the mux decides whether they are used.
   assign cmp_a     = add_a_q[CMP_W-1:0];
   assign cmp_b     = add_b_q[CMP_W-1:0];
   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;
   assign out_co    = out_co_q;

endmodule

// File: tb/tb_operand_dispatch.sv
// Two dispatchers (LAT=1 and LAT=3), each wrapped around a behavioural adder, comparator
// and result mux, driven with directed and random operations.
module tb_operand_dispatch;
   import adder_pkg::*;

   localparam int unsigned N    = 16;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic             in_valid  [2];
   logic             in_ready  [2];
   logic [N-1:0]     in_a      [2];
   logic [N-1:0]     in_b      [2];
   logic             in_cin    [2];
   logic             in_op     [2];
   logic [N-1:0]     add_a     [2];
   logic [N-1:0]     add_b     [2];
   logic             add_cin   [2];
   logic [CMP_W-1:0] cmp_a     [2];
   logic [CMP_W-1:0] cmp_b     [2];
   logic             sel       [2];
   logic [N-1:0]     res_in    [2];
   logic             co_in     [2];
   logic             out_valid [2];
   logic             out_ready [2];
   logic [N-1:0]     out_res   [2];
   logic             out_co    [2];

   operand_dispatch #(.N(N), .LAT(LAT0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .in_op(in_op[0]),
      .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
      .cmp_a(cmp_a[0]), .cmp_b(cmp_b[0]), .sel(sel[0]),
      .res_in(res_in[0]), .co_in(co_in[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_res(out_res[0]), .out_co(out_co[0])
   );

   operand_dispatch #(.N(N), .LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .in_op(in_op[1]),
      .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
      .cmp_a(cmp_a[1]), .cmp_b(cmp_b[1]), .sel(sel[1]),
      .res_in(res_in[1]), .co_in(co_in[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_res(out_res[1]), .out_co(out_co[1])
   );

   // Surrounding datapath: adder, comparator ({lt, eq, gt} in the low bits), result mux.
   for (genvar g = 0; g < 2; g++) begin : g_dp
      logic [N:0]       sum;
      logic [CMP_W-1:0] cmpo;
      assign sum  = {1'b0, add_a[g]} + {1'b0, add_b[g]} + {{N{1'b0}}, add_cin[g]};
      assign cmpo = {3'b000, cmp_a[g] < cmp_b[g], cmp_a[g] == cmp_b[g], cmp_a[g] > cmp_b[g]};
      assign res_in[g] = sel[g] ? {sum[N-1:CMP_W], cmpo} : sum[N-1:0];
      assign co_in[g]  = sum[N];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {carry, result} from plain integer arithmetic on the operation itself.
   function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic cin, input logic op);
      int unsigned s, la, lb, code;
      s  = int'(a) + int'(b) + int'(cin);
      la = int'(a) % 64;
      lb = int'(b) % 64;
      code = (la < lb) ? 4 : (la == lb) ? 2 : 1;
      if (op == OP_CMP) s = (s / 64) * 64 + code;
      return (N+1)'(s);
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? int'(LAT0) : int'(LAT1);
   endfunction

   task automatic run_op(input int d, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic op, input int hold,
                         input bit keep_valid, output int acc_cyc);
      logic [N:0] exp;
      int n;
      exp = model(a, b, cin, op);
      in_valid[d]  = 1'b1;
      in_a[d]      = a;
      in_b[d]      = b;
      in_cin[d]    = cin;
      in_op[d]     = op;
      out_ready[d] = (hold == 0);
      chk("ready_before_accept", in_ready[d], 1);
      @(negedge clk);
      acc_cyc = cyc;
      chk("ready_low_exec", in_ready[d], 0);
      chk("add_a", add_a[d], a);
      chk("add_b", add_b[d], b);
      chk("add_cin", add_cin[d], cin);
      chk("sel", sel[d], op);
      chk("cmp_a", cmp_a[d], a % 64);
      chk("cmp_b", cmp_b[d], b % 64);
      if (!keep_valid) in_valid[d] = 1'b0;
      n = 0;
      while (!out_valid[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat_of(d));
      chk("out_res", out_res[d], exp[N-1:0]);
      chk("out_co", out_co[d], exp[N]);
      chk("ready_low_hold", in_ready[d], 0);
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = 1'($urandom);
         in_a[d]     = N'($urandom);
         in_b[d]     = N'($urandom);
         @(negedge clk);
         chk("hold_valid", out_valid[d], 1);
         chk("hold_res", out_res[d], exp[N-1:0]);
         chk("hold_co", out_co[d], exp[N]);
         chk("hold_no_accept", add_a[d], a);
         chk("hold_ready", in_ready[d], 0);
      end
      in_valid[d]  = keep_valid;
      out_ready[d] = 1'b1;
      @(negedge clk);
      chk("valid_cleared", out_valid[d], 0);
      chk("ready_back", in_ready[d], 1);
   endtask

   initial begin
      int acc, prev;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b1;
         in_a[d]      = 16'h1234;
         in_b[d]      = 16'h0F0F;
         in_cin[d]    = 1'b1;
         in_op[d]     = OP_ADD;
         out_ready[d] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", in_ready[d], 1);
         chk("rst_out_valid", out_valid[d], 0);
         chk("rst_add_a", add_a[d], 0);
         chk("rst_add_b", add_b[d], 0);
         chk("rst_add_cin", add_cin[d], 0);
         chk("rst_sel", sel[d], 0);
         chk("rst_cmp_a", cmp_a[d], 0);
         chk("rst_out_res", out_res[d], 0);
         chk("rst_out_co", out_co[d], 0);
      end
      in_valid[1] = 1'b0;
      rst_n = 1'b1;

      // LAT=1 add accepted on the first edge after reset release.
      run_op(0, 16'h1234, 16'h0F0F, 1'b1, OP_ADD, 0, 0, acc);
      // LAT=3 compare.
      run_op(1, 16'hAB05, 16'h0003, 1'b0, OP_CMP, 0, 0, acc);
      // Consumer stalls in HOLD.
      run_op(0, 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 5, 0, acc);
      run_op(1, 16'h0041, 16'h0081, 1'b1, OP_CMP, 5, 0, acc);

      // Back-to-back with in_valid held high.
      for (int d = 0; d < 2; d++) begin
         prev = -1;
         for (int i = 0; i < 4; i++) begin
            run_op(d, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 0, 1, acc);
            if (prev >= 0) chk("b2b_spacing", acc - prev, lat_of(d) + 2);
            prev = acc;
         end
         in_valid[d] = 1'b0;
      end

      // Reset in mid-EXEC aborts without a result.
      in_valid[1] = 1'b1;
      in_a[1]     = 16'h5555;
      in_b[1]     = 16'h1111;
      in_op[1]    = OP_ADD;
      @(negedge clk);
      in_valid[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid[1], 0);
      chk("abort_in_ready", in_ready[1], 1);
      chk("abort_add_a", add_a[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_result", out_valid[1], 0);
      end
      run_op(1, 16'h7FFF, 16'h8000, 1'b1, OP_ADD, 0, 0, acc);

      // Random operations on both instances.
      for (int i = 0; i < 24; i++) begin
         run_op(int'($urandom_range(1, 0)), N'($urandom), N'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(3, 0)), 0, acc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
